// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 filter datapath: pixel width, window tap
// ordering and the window generator's state encoding.
package filter_pkg;

    localparam int PIX_W = 8;

    // Window taps in row-major order: top-left = 1, centre = 5, bottom-right = 9
    localparam int TAP_TL = 1;
    localparam int TAP_TM = 2;
    localparam int TAP_TR = 3;
    localparam int TAP_ML = 4;
    localparam int TAP_MM = 5;
    localparam int TAP_MR = 6;
    localparam int TAP_BL = 7;
    localparam int TAP_BM = 8;
    localparam int TAP_BR = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage. A single address serves both ports: the
// read returns the old contents while the write lands on the clock edge.
// Storage is not reset.
module line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    assign rd_data = mem[addr];

    // Write port; the read above sees the pre-write value in the same cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sliding_window_gen.sv
// Raster-order pixel stream to 3x3 neighbourhood generator. Two line buffers
// keep rows r-2 and r-1; a 3x3 shift register forms the window. One window
// per accepted interior-completing pixel, valid region only, no stall path.
module sliding_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = filter_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic [PIX_W-1:0] sw_pixels1,
    output logic [PIX_W-1:0] sw_pixels2,
    output logic [PIX_W-1:0] sw_pixels3,
    output logic [PIX_W-1:0] sw_pixels4,
    output logic [PIX_W-1:0] sw_pixels5,
    output logic [PIX_W-1:0] sw_pixels6,
    output logic [PIX_W-1:0] sw_pixels7,
    output logic [PIX_W-1:0] sw_pixels8,
    output logic [PIX_W-1:0] sw_pixels9,
    output logic             act,
    output logic             busy,
    output logic             frame_done
);

    import filter_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_t state;
    state_t state_next;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;

    logic sof_acc;
    logic accept;
    logic at_last;

    logic [PIX_W-1:0] top_rd;
    logic [PIX_W-1:0] mid_rd;

    logic [PIX_W-1:0] win [1:9];
    logic             act_r;
    logic             done_r;

    // Accept qualification and the position of the pixel on the input this
    // cycle; a sof forces (0,0) so an abandoned frame restarts in place.
    always_comb begin
        sof_acc = in_valid & in_sof;
        accept  = in_valid & ((state != IDLE) | in_sof);
        cur_col = sof_acc ? '0 : col;
        cur_row = sof_acc ? '0 : row;
        at_last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a sof in any state (re)starts filling
    always_comb begin
        state_next = state;
        if (sof_acc) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL: begin
                    if (accept && (cur_row == ROW_TWO) && (cur_col == '0)) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (accept && at_last) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // Busy also covers the sof cycle itself so back-to-back frames never
    // show a gap between the last pixel of one and the sof of the next.
    always_comb begin
        busy = ~rst & ((state != IDLE) | sof_acc);
    end

    // Raster position counters, advanced only on accepted pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) lb_top (
        .clk     (clk),
        .we      (accept),
        .addr    (cur_col),
        .wr_data (mid_rd),
        .rd_data (top_rd)
    );

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) lb_mid (
        .clk     (clk),
        .we      (accept),
        .addr    (cur_col),
        .wr_data (in_pixel),
        .rd_data (mid_rd)
    );

    // Window shift: columns move left, new right column from the line buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned t = 1; t <= 9; t++) begin
                win[t] <= '0;
            end
        end else if (accept) begin
            win[TAP_TL] <= win[TAP_TM];
            win[TAP_TM] <= win[TAP_TR];
            win[TAP_TR] <= top_rd;
            win[TAP_ML] <= win[TAP_MM];
            win[TAP_MM] <= win[TAP_MR];
            win[TAP_MR] <= mid_rd;
            win[TAP_BL] <= win[TAP_BM];
            win[TAP_BM] <= win[TAP_BR];
            win[TAP_BR] <= in_pixel;
        end
    end

    // Window-valid and end-of-frame strobes; the col >= 2 term masks the
    // stale columns left over from the previous row.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            act_r  <= accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
            done_r <= accept && at_last && (state == RUN);
        end
    end

    assign act        = act_r;
    assign frame_done = done_r;

    assign sw_pixels1 = win[TAP_TL];
    assign sw_pixels2 = win[TAP_TM];
    assign sw_pixels3 = win[TAP_TR];
    assign sw_pixels4 = win[TAP_ML];
    assign sw_pixels5 = win[TAP_MM];
    assign sw_pixels6 = win[TAP_MR];
    assign sw_pixels7 = win[TAP_BL];
    assign sw_pixels8 = win[TAP_BM];
    assign sw_pixels9 = win[TAP_BR];

endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed bench for sliding_window_gen: a 4x4 instance and a 5x3 instance
// share one input stream; each test starts with a sof so both resynchronise.
module tb_sliding_window_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_pixel;

    logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic       act4, busy4, done4;
    logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
    logic       act5, busy5, done5;

    always #5 clk = ~clk;

    sliding_window_gen #(
        .IMG_W (4),
        .IMG_H (4),
        .PIX_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .sw_pixels1 (a1),
        .sw_pixels2 (a2),
        .sw_pixels3 (a3),
        .sw_pixels4 (a4),
        .sw_pixels5 (a5),
        .sw_pixels6 (a6),
        .sw_pixels7 (a7),
        .sw_pixels8 (a8),
        .sw_pixels9 (a9),
        .act        (act4),
        .busy       (busy4),
        .frame_done (done4)
    );

    sliding_window_gen #(
        .IMG_W (5),
        .IMG_H (3),
        .PIX_W (8)
    ) dut5 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .sw_pixels1 (b1),
        .sw_pixels2 (b2),
        .sw_pixels3 (b3),
        .sw_pixels4 (b4),
        .sw_pixels5 (b5),
        .sw_pixels6 (b6),
        .sw_pixels7 (b7),
        .sw_pixels8 (b8),
        .sw_pixels9 (b9),
        .act        (act5),
        .busy       (busy5),
        .frame_done (done5)
    );

    typedef struct {
        logic        e_act;
        logic        e_done;
        logic [71:0] e_win;
    } vec_t;

    vec_t tbl [16];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   acts;
    int   dones;
    logic busy_pre;
    logic busy_min;

    function automatic logic [71:0] win4();
        return {a1, a2, a3, a4, a5, a6, a7, a8, a9};
    endfunction

    function automatic logic [71:0] win5();
        return {b1, b2, b3, b4, b5, b6, b7, b8, b9};
    endfunction

    function automatic logic [71:0] offs(input logic [71:0] w, input int base);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) begin
            r[k*8 +: 8] = w[k*8 +: 8] + 8'(base);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of input; busy is sampled at the negedge while the
    // inputs are live, registered outputs just after the accepting edge.
    task automatic step(input logic v, input logic s, input logic [7:0] p);
        in_valid = v;
        in_sof   = s;
        in_pixel = p;
        @(negedge clk);
        busy_pre = busy4;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int base, input bit gap);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i == 0), 8'(base + i));
            busy_min &= busy_pre;
            chk($sformatf("act b%0d p%0d", base, i), 72'(act4), 72'(tbl[i].e_act));
            chk($sformatf("done b%0d p%0d", base, i), 72'(done4), 72'(tbl[i].e_done));
            if (tbl[i].e_act) begin
                chk($sformatf("win b%0d p%0d", base, i), win4(), offs(tbl[i].e_win, base));
            end
            acts  += int'(act4);
            dones += int'(done4);
            if (gap) begin
                step(1'b0, 1'b0, 8'h00);
                busy_min &= busy_pre;
                chk($sformatf("gap act p%0d", i), 72'(act4), 72'(0));
                chk($sformatf("gap done p%0d", i), 72'(done4), 72'(0));
                if (tbl[i].e_act) begin
                    chk($sformatf("gap hold p%0d", i), win4(), offs(tbl[i].e_win, base));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].e_act  = 1'b0;
            tbl[i].e_done = 1'b0;
            tbl[i].e_win  = '0;
        end
        tbl[10].e_act = 1'b1;
        tbl[10].e_win = 72'h00_01_02_04_05_06_08_09_0A;
        tbl[11].e_act = 1'b1;
        tbl[11].e_win = 72'h01_02_03_05_06_07_09_0A_0B;
        tbl[14].e_act = 1'b1;
        tbl[14].e_win = 72'h04_05_06_08_09_0A_0C_0D_0E;
        tbl[15].e_act  = 1'b1;
        tbl[15].e_done = 1'b1;
        tbl[15].e_win  = 72'h05_06_07_09_0A_0B_0D_0E_0F;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset act", 72'(act4), 72'(0));
        chk("reset busy", 72'(busy4), 72'(0));
        chk("reset done", 72'(done4), 72'(0));
        chk("reset win", win4(), 72'(0));
        rst = 1'b0;

        // 4x4 continuous frame
        acts  = 0;
        dones = 0;
        run_frame(0, 1'b0);
        chk("f1 act count", 72'(acts), 72'(4));
        chk("f1 done count", 72'(dones), 72'(1));
        step(1'b0, 1'b0, 8'h00);
        chk("f1 busy after", 72'(busy4), 72'(0));

        // Same frame with a gap after every pixel
        acts = 0;
        run_frame(0, 1'b1);
        chk("gap act count", 72'(acts), 72'(4));

        // 5x3 wrap check on the second instance
        for (int i = 0; i < 15; i++) begin
            step(1'b1, (i == 0), 8'(i));
            chk($sformatf("w5 act p%0d", i), 72'(act5), 72'(i >= 12));
            chk($sformatf("w5 done p%0d", i), 72'(done5), 72'(i == 14));
            if (i >= 12) begin
                chk($sformatf("w5 centre p%0d", i), 72'(b5), 72'(i - 6));
            end
            if (i == 12) begin
                chk("w5 first win", win5(), 72'h00_01_02_05_06_07_0A_0B_0C);
            end
        end

        // Frame A abandoned at pixel 6 by the sof of frame B
        for (int i = 0; i < 7; i++) begin
            step(1'b1, (i == 0), 8'(i));
            chk($sformatf("A done p%0d", i), 72'(done4), 72'(0));
            chk($sformatf("A act p%0d", i), 72'(act4), 72'(0));
        end
        acts  = 0;
        dones = 0;
        run_frame(100, 1'b0);
        chk("B done count", 72'(dones), 72'(1));

        // Reset mid-frame after pixel 9
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i == 0), 8'(i + 40));
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst act", 72'(act4), 72'(0));
        chk("rst busy", 72'(busy4), 72'(0));
        chk("rst done", 72'(done4), 72'(0));
        chk("rst win", win4(), 72'(0));
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 8'(i + 20));
            chk($sformatf("post-rst act %0d", i), 72'(act4), 72'(0));
            chk($sformatf("post-rst busy %0d", i), 72'(busy_pre), 72'(0));
        end
        run_frame(0, 1'b0);

        // Two frames back-to-back
        acts     = 0;
        dones    = 0;
        busy_min = 1'b1;
        run_frame(0, 1'b0);
        run_frame(0, 1'b0);
        chk("b2b act count", 72'(acts), 72'(8));
        chk("b2b done count", 72'(dones), 72'(2));
        chk("b2b busy held", 72'(busy_min), 72'(1));
        step(1'b0, 1'b0, 8'h00);
        chk("b2b busy after", 72'(busy4), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
